// File: rtl/pong_pkg.sv
// rtl/pong_pkg.sv - shared state, shift-mode and scoring constants for the pong rally controller
package pong_pkg;

  // One-hot encoding; bit index doubles as the LED/debug display position
  typedef enum logic [6:0] {
    ST_IDLE    = 7'b0000001,
    ST_SERVE_L = 7'b0000010,
    ST_SERVE_R = 7'b0000100,
    ST_MOVE_R  = 7'b0001000,
    ST_MOVE_L  = 7'b0010000,
    ST_POINT   = 7'b0100000,
    ST_OVER    = 7'b1000000
  } state_e;

  typedef logic [1:0] shmode_t;

  localparam shmode_t SH_HOLD  = 2'b00;
  localparam shmode_t SH_RIGHT = 2'b01;
  localparam shmode_t SH_LEFT  = 2'b10;
  localparam shmode_t SH_LOAD  = 2'b11;

  localparam int WIN_SCORE_DEF = 7;

endpackage

// File: rtl/pong_tick_div.sv
// rtl/pong_tick_div.sv - ball-step divider: tick on the last of every TICK_DIV cycles, held at 0 while clr
module pong_tick_div #(
  parameter int TICK_DIV = 4,
  parameter int TICK_W   = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic tick
);

  localparam logic [TICK_W-1:0] LAST = TICK_W'(TICK_DIV - 1);

  logic [TICK_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr || cnt_q == LAST) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + TICK_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = (cnt_q == LAST);

endmodule

// File: rtl/pong_rally_controller.sv
// rtl/pong_rally_controller.sv - two-player rally sequencer driving the LED ball shift register
// Optional HIT_LOCKOUT_EN: an early paddle press locks that player out for the rest of the rally.
module pong_rally_controller
  import pong_pkg::*;
#(
  parameter int TICK_DIV  = 4,
  parameter int TICK_W    = 3,
  parameter int WIN_SCORE = WIN_SCORE_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       lsrv,
  input  logic       rsrv,
  input  logic       lhit,
  input  logic       rhit,
  input  logic       qleft,
  input  logic       qright,
  output logic [1:0] s,
  output logic       lsi,
  output logic       rsi,
  output logic [3:0] lscore,
  output logic [3:0] rscore,
  output logic       server,
  output logic       game_over,
  output logic [6:0] state
);

  localparam logic [3:0] WIN4 = 4'(WIN_SCORE);

  state_e     state_q, state_d;
  logic [3:0] lscore_q, lscore_d;
  logic [3:0] rscore_q, rscore_d;
  logic       server_q, server_d;
  logic       lhit_lat_q, lhit_lat_d;
  logic       rhit_lat_q, rhit_lat_d;
  logic       llock_q, llock_d;
  logic       rlock_q, rlock_d;
  logic       tick;
  logic       moving;
  shmode_t    s_fsm;
  logic       lsi_fsm, rsi_fsm;

  assign moving = (state_q == ST_MOVE_R) || (state_q == ST_MOVE_L);

  pong_tick_div #(
    .TICK_DIV(TICK_DIV),
    .TICK_W  (TICK_W)
  ) u_tick_div (
    .clk  (clk),
    .reset(reset),
    .clr  (!moving),
    .tick (tick)
  );

  always_comb begin
    state_d    = state_q;
    lscore_d   = lscore_q;
    rscore_d   = rscore_q;
    server_d   = server_q;
    lhit_lat_d = lhit_lat_q;
    rhit_lat_d = rhit_lat_q;
    llock_d    = llock_q;
    rlock_d    = rlock_q;
    s_fsm      = SH_HOLD;
    lsi_fsm    = 1'b0;
    rsi_fsm    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        s_fsm = SH_LOAD;
        if (!server_q && lsrv) begin
          state_d = ST_SERVE_L;
        end else if (server_q && rsrv) begin
          state_d = ST_SERVE_R;
        end
      end
      ST_SERVE_L: begin
        s_fsm   = SH_RIGHT;
        rsi_fsm = 1'b1;
        state_d = ST_MOVE_R;
      end
      ST_SERVE_R: begin
        s_fsm   = SH_LEFT;
        lsi_fsm = 1'b1;
        state_d = ST_MOVE_L;
      end
      ST_MOVE_R: begin
        if (qright && rhit) rhit_lat_d = 1'b1;
`ifdef HIT_LOCKOUT_EN
        if (!qright && rhit) rlock_d = 1'b1;
`endif
        if (tick) begin
          if (!qright) begin
            s_fsm = SH_RIGHT;
          end else if ((rhit_lat_q || rhit) && !rlock_q) begin
            s_fsm      = SH_LEFT;
            lhit_lat_d = 1'b0;
            rhit_lat_d = 1'b0;
            state_d    = ST_MOVE_L;
          end else begin
            s_fsm    = SH_LOAD;
            lscore_d = lscore_q + 4'd1;
            server_d = 1'b0;
            state_d  = ST_POINT;
          end
        end
      end
      ST_MOVE_L: begin
        if (qleft && lhit) lhit_lat_d = 1'b1;
`ifdef HIT_LOCKOUT_EN
        if (!qleft && lhit) llock_d = 1'b1;
`endif
        if (tick) begin
          if (!qleft) begin
            s_fsm = SH_LEFT;
          end else if ((lhit_lat_q || lhit) && !llock_q) begin
            s_fsm      = SH_RIGHT;
            lhit_lat_d = 1'b0;
            rhit_lat_d = 1'b0;
            state_d    = ST_MOVE_R;
          end else begin
            s_fsm    = SH_LOAD;
            rscore_d = rscore_q + 4'd1;
            server_d = 1'b1;
            state_d  = ST_POINT;
          end
        end
      end
      ST_POINT: begin
        lhit_lat_d = 1'b0;
        rhit_lat_d = 1'b0;
        llock_d    = 1'b0;
        rlock_d    = 1'b0;
        // server already points at whoever just won the point
        if ((server_q ? rscore_q : lscore_q) == WIN4) begin
          state_d = ST_OVER;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_OVER: begin
        s_fsm = SH_LOAD;
      end
      default: begin
        s_fsm   = SH_LOAD;
        state_d = ST_IDLE;
      end
    endcase
  end

  // Reset clears the ball register in the same cycle it is asserted
  always_comb begin
    s   = s_fsm;
    lsi = lsi_fsm;
    rsi = rsi_fsm;
    if (reset) begin
      s   = SH_LOAD;
      lsi = 1'b0;
      rsi = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      lscore_q   <= 4'd0;
      rscore_q   <= 4'd0;
      server_q   <= 1'b0;
      lhit_lat_q <= 1'b0;
      rhit_lat_q <= 1'b0;
      llock_q    <= 1'b0;
      rlock_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      lscore_q   <= lscore_d;
      rscore_q   <= rscore_d;
      server_q   <= server_d;
      lhit_lat_q <= lhit_lat_d;
      rhit_lat_q <= rhit_lat_d;
      llock_q    <= llock_d;
      rlock_q    <= rlock_d;
    end
  end

  assign lscore    = lscore_q;
  assign rscore    = rscore_q;
  assign server    = server_q;
  assign game_over = (state_q == ST_OVER);
  assign state     = state_q;

endmodule

// File: tb/tb_pong_rally_controller.sv
// tb/tb_pong_rally_controller.sv - randomized rally play against a ball-position game model
// Honours HIT_LOCKOUT_EN the same way the design does.
module tb_pong_rally_controller;

  localparam int TICK_DIV = 4;
  localparam int TICK_W   = 3;
  localparam int WIN      = 7;
  localparam int NCYC     = 30000;

  localparam int P_WAIT = 0, P_SRVL = 1, P_SRVR = 2, P_FLYR = 3, P_FLYL = 4, P_POINT = 5, P_OVER = 6;

  logic       clk = 1'b0;
  logic       reset, lsrv, rsrv, lhit, rhit;
  logic       qleft, qright;
  logic [1:0] s;
  logic       lsi, rsi;
  logic [3:0] lscore, rscore;
  logic       server, game_over;
  logic [6:0] state;
  logic [7:0] led_q = 8'h00;

  int vectors = 0;
  int miscompares = 0;

  pong_rally_controller #(
    .TICK_DIV (TICK_DIV),
    .TICK_W   (TICK_W),
    .WIN_SCORE(WIN)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .lsrv     (lsrv),
    .rsrv     (rsrv),
    .lhit     (lhit),
    .rhit     (rhit),
    .qleft    (qleft),
    .qright   (qright),
    .s        (s),
    .lsi      (lsi),
    .rsi      (rsi),
    .lscore   (lscore),
    .rscore   (rscore),
    .server   (server),
    .game_over(game_over),
    .state    (state)
  );

  always #5 clk = ~clk;

  // The LED ball register on the board, driven by the DUT's own mode outputs
  assign qleft  = led_q[7];
  assign qright = led_q[0];
  always @(posedge clk) begin
    case (s)
      2'b01:   led_q <= {rsi, led_q[7:1]};
      2'b10:   led_q <= {led_q[6:0], lsi};
      2'b11:   led_q <= 8'h00;
      default: led_q <= led_q;
    endcase
  end

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Game model: phase, ball position 0 (left end) .. 7 (right end), -1 = no ball
  int m_phase = P_WAIT, m_pos = -1, m_fly = 0, m_ls = 0, m_rs = 0, m_server = 0;
  bit m_pend = 0;
  bit m_lock[2] = '{0, 0};

  initial begin
    int n_phase, n_pos, n_fly, n_ls, n_rs, n_server, over_cycles;
    bit n_pend, going_r, at_end, hit, tk;
    bit n_lock[2];
    int exp_s, exp_lsi, exp_rsi;

    reset = 1'b1; lsrv = 0; rsrv = 0; lhit = 0; rhit = 0;
    repeat (2) @(posedge clk);
    over_cycles = 0;

    for (int i = 0; i < NCYC; i++) begin
      @(negedge clk);
      reset = (i < 2) || ($urandom_range(0, 2999) == 0) || (over_cycles >= 20);
      lsrv  = ($urandom_range(0, 3) == 0);
      rsrv  = ($urandom_range(0, 3) == 0);
      lhit  = qleft  ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 59) == 0);
      rhit  = qright ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 59) == 0);
      #1;

      exp_s = 3; exp_lsi = 0; exp_rsi = 0;
      n_phase = m_phase; n_fly = m_fly; n_ls = m_ls; n_rs = m_rs; n_server = m_server;
      n_pend = m_pend; n_lock = m_lock;

      if (reset) begin
        n_phase = P_WAIT; n_ls = 0; n_rs = 0; n_server = 0; n_pend = 0; n_lock = '{0, 0};
      end else begin
        case (m_phase)
          P_WAIT: begin
            if (m_server == 0 && lsrv) n_phase = P_SRVL;
            else if (m_server == 1 && rsrv) n_phase = P_SRVR;
          end
          P_SRVL: begin exp_s = 1; exp_rsi = 1; n_phase = P_FLYR; n_fly = 0; end
          P_SRVR: begin exp_s = 2; exp_lsi = 1; n_phase = P_FLYL; n_fly = 0; end
          P_FLYR, P_FLYL: begin
            going_r = (m_phase == P_FLYR);
            at_end  = going_r ? (m_pos == 7) : (m_pos == 0);
            hit     = going_r ? rhit : lhit;
            tk      = (m_fly % TICK_DIV) == TICK_DIV - 1;
            n_fly   = m_fly + 1;
            exp_s   = 0;
            if (at_end && hit) n_pend = 1;
`ifdef HIT_LOCKOUT_EN
            if (!at_end && hit) n_lock[going_r] = 1;
`endif
            if (tk) begin
              if (!at_end) begin
                exp_s = going_r ? 1 : 2;
              end else if ((m_pend || hit) && !m_lock[going_r]) begin
                exp_s   = going_r ? 2 : 1;
                n_pend  = 0;
                n_phase = going_r ? P_FLYL : P_FLYR;
              end else begin
                exp_s = 3;
                if (going_r) n_ls = m_ls + 1; else n_rs = m_rs + 1;
                n_server = going_r ? 0 : 1;
                n_phase  = P_POINT;
              end
            end
          end
          P_POINT: begin
            exp_s = 0; n_pend = 0; n_lock = '{0, 0};
            n_phase = (((m_server == 1) ? m_rs : m_ls) == WIN) ? P_OVER : P_WAIT;
          end
          default: exp_s = 3;
        endcase
      end

      check("s", 8'(s), 8'(exp_s));
      check("lsi", 8'(lsi), 8'(exp_lsi));
      check("rsi", 8'(rsi), 8'(exp_rsi));
      check("lscore", 8'(lscore), 8'(m_ls));
      check("rscore", 8'(rscore), 8'(m_rs));
      check("server", 8'(server), 8'(m_server));
      check("game_over", 8'(game_over), 8'(m_phase == P_OVER));
      check("state", 8'(state), 8'(1 << m_phase));

      // Ball motion follows the expected mode, independent of the LED register
      n_pos = m_pos;
      case (exp_s)
        1: n_pos = exp_rsi ? 0 : ((m_pos < 0 || m_pos == 7) ? -1 : m_pos + 1);
        2: n_pos = exp_lsi ? 7 : ((m_pos <= 0) ? -1 : m_pos - 1);
        3: n_pos = -1;
        default: ;
      endcase

      @(posedge clk);
      #1;
      m_phase = n_phase; m_pos = n_pos; m_fly = n_fly; m_ls = n_ls; m_rs = n_rs;
      m_server = n_server; m_pend = n_pend; m_lock = n_lock;
      over_cycles = (m_phase == P_OVER) ? over_cycles + 1 : 0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
